// File: rtl/dkong_wav_pkg.sv
// Shared types and constants for the Donkey Kong walk/jump/foot sample fetch path.
// Used by the wave fetch block and its sample-rate tick generator.
package dkong_wav_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;

  localparam int         WAV_SAMPLE_RATE = 11025;
  localparam logic [7:0] PCM_ZERO        = 8'h80;
  localparam int         ROM_AW          = 19;
endpackage

// File: rtl/dkong_wav_tick.sv
// Sample-rate strobe: one-cycle O_TICK every CLOCK_RATE/WAV_SAMPLE_RATE clocks (12-bit divider).
// Phase starts at 0 on reset so it lines up with the wave sequencer's own divider.
module dkong_wav_tick
  import dkong_wav_pkg::*;
#(
  parameter int CLOCK_RATE = 24000000
) (
  input  logic I_CLK,
  input  logic I_RSTn,
  output logic O_TICK
);
  localparam int SAMPLE_CNT = CLOCK_RATE / WAV_SAMPLE_RATE;

  logic [11:0] div;

  assign O_TICK = (div == 12'(SAMPLE_CNT - 1));

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn)     div <= '0;
    else if (O_TICK) div <= '0;
    else             div <= div + 12'd1;
  end
endmodule

// File: rtl/dkong_wav_fetch.sv
// Fetches sequencer-addressed PCM bytes over req/ack, converts to signed 16-bit, mutes on stall/timeout.
// Define DKWAV_LPF_EN to add a one-pole low-pass (updated on sample ticks) on the output.
module dkong_wav_fetch
  import dkong_wav_pkg::*;
#(
  parameter int CLOCK_RATE = 24000000,
  parameter int GAIN_SHIFT = 7,
  parameter int TIMEOUT    = 255,
  parameter int IDLE_TICKS = 4,
  parameter int LPF_SHIFT  = 2
) (
  input  logic              I_CLK,
  input  logic              I_RSTn,
  input  logic [ROM_AW-1:0] I_ROM_AB,
  output logic              O_ROM_RD,
  output logic [ROM_AW-1:0] O_ROM_A,
  input  logic              I_ROM_ACK,
  input  logic [7:0]        I_ROM_DO,
  output logic [15:0]       O_SOUND,
  output logic              O_ERR
);
  localparam int IDLE_CW = $clog2(IDLE_TICKS + 1);

  fetch_state_t        state;
  logic [ROM_AW-1:0]   last_addr;
  logic [7:0]          pcm, pcm_nxt;
  logic [7:0]          tmo_cnt;
  logic [IDLE_CW-1:0]  idle_cnt, idle_nxt;
  logic                tick, start, timeout_hit;
  logic signed [15:0]  pcm_ext, x_nxt;

  dkong_wav_tick #(.CLOCK_RATE(CLOCK_RATE)) u_tick (
    .I_CLK  (I_CLK),
    .I_RSTn (I_RSTn),
    .O_TICK (tick)
  );

  assign start       = (state == IDLE) && (I_ROM_AB != last_addr);
  assign timeout_hit = (state == WAIT) && !I_ROM_ACK && (tmo_cnt == 8'(TIMEOUT));

  // Next pcm/mute are used so O_SOUND moves on the same edge that captures the ack.
  always_comb begin
    pcm_nxt  = pcm;
    idle_nxt = idle_cnt;
    if (state == WAIT && I_ROM_ACK) pcm_nxt = I_ROM_DO ^ PCM_ZERO;
    else if (timeout_hit)           pcm_nxt = '0;
    if (start)
      idle_nxt = '0;
    else if (tick && (I_ROM_AB == last_addr) && (idle_cnt < IDLE_CW'(IDLE_TICKS)))
      idle_nxt = idle_cnt + 1'b1;
  end

  assign pcm_ext = {{8{pcm_nxt[7]}}, pcm_nxt};
  assign x_nxt   = (idle_nxt >= IDLE_CW'(IDLE_TICKS)) ? 16'sd0 : (pcm_ext <<< GAIN_SHIFT);

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state     <= IDLE;
      O_ROM_RD  <= 1'b0;
      O_ROM_A   <= '0;
      last_addr <= '0;
      pcm       <= '0;
      O_ERR     <= 1'b0;
      tmo_cnt   <= '0;
      idle_cnt  <= IDLE_CW'(IDLE_TICKS);
    end else begin
      pcm      <= pcm_nxt;
      idle_cnt <= idle_nxt;
      case (state)
        IDLE: if (start) begin
          O_ROM_A   <= I_ROM_AB;
          last_addr <= I_ROM_AB;
          O_ROM_RD  <= 1'b1;
          state     <= REQ;
        end
        REQ: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (I_ROM_ACK) begin
            O_ROM_RD <= 1'b0;
            state    <= IDLE;
          end else if (timeout_hit) begin
            O_ROM_RD <= 1'b0;
            O_ERR    <= 1'b1;
            state    <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DKWAV_LPF_EN
  logic signed [15:0] lpf_y;
  logic signed [16:0] lpf_diff;

  assign lpf_diff = $signed({x_nxt[15], x_nxt}) - $signed({lpf_y[15], lpf_y});

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn)   lpf_y <= '0;
    else if (tick) lpf_y <= lpf_y + 16'(lpf_diff >>> LPF_SHIFT);
  end

  assign O_SOUND = lpf_y;
`else
  localparam int unused_lpf_shift = LPF_SHIFT;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) O_SOUND <= '0;
    else         O_SOUND <= x_nxt;
  end
`endif
endmodule
